// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// The timer width helper keeps the down-stream timer sizing in one place.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam int DEFAULT_TIMEOUT = 16;
    localparam int DEFAULT_WIDTH   = 32;

    // A timeout of 1 would still need a one-bit timer.
    function automatic int timer_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_cmp.sv
// Equality compare of the incoming PC against the last delivered PC.
// Kept separate so the compare can be retimed or widened on its own.
module pc_fetch_ctrl_cmp
    import fetch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);

    assign eq = (a == b);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: one memory read per PC change, response timeout/retry,
// late-response discard and flush, word held on valid/ready until taken.
//
// state | meaning
// IDLE  | waiting for a PC that differs from the last delivered one
// REQ   | mem_req high with addr_q until mem_gnt
// WAIT  | granted, waiting for mem_rvalid; times out and re-requests
// HOLD  | instr_valid high with data_q until instr_ready
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    input  logic             pc_valid,
    input  logic             flush,
    output logic             same_pc,
    output logic             busy,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic             err
);

    localparam int            TW         = timer_width(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    fetch_state_t     state, state_nxt;
    logic [WIDTH-1:0] last_pc, last_pc_nxt;
    logic [WIDTH-1:0] addr_q, addr_nxt;
    logic [WIDTH-1:0] data_q, data_nxt;
    logic             seen, seen_nxt;
    logic             drop, drop_nxt;
    logic [TW-1:0]    timer, timer_nxt;

    logic pc_eq;
    logic start;
    logic rsp_take;
    logic timeout_hit;

    pc_fetch_ctrl_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a  (pc),
        .b  (last_pc),
        .eq (pc_eq)
    );

    assign same_pc     = pc_eq & seen;
    assign start       = pc_valid & ~same_pc;
    // A response arriving while drop is set belongs to an abandoned request.
    assign rsp_take    = mem_rvalid & ~drop;
    assign timeout_hit = (state == WAIT) & ~rsp_take & (timer == TIMER_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            last_pc <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            seen    <= 1'b0;
            drop    <= 1'b0;
            timer   <= '0;
        end else begin
            state   <= state_nxt;
            last_pc <= last_pc_nxt;
            addr_q  <= addr_nxt;
            data_q  <= data_nxt;
            seen    <= seen_nxt;
            drop    <= drop_nxt;
            timer   <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        last_pc_nxt = last_pc;
        addr_nxt    = addr_q;
        data_nxt    = data_q;
        seen_nxt    = seen;
        timer_nxt   = timer;
        drop_nxt    = drop & ~mem_rvalid;

        if (flush) begin
            state_nxt = IDLE;
            seen_nxt  = 1'b0;
            // A request already granted will still answer; swallow it.
            if ((state == WAIT) || ((state == REQ) && mem_gnt)) begin
                drop_nxt = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_nxt  = pc;
                        state_nxt = REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        timer_nxt = '0;
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_take) begin
                        data_nxt  = mem_rdata;
                        state_nxt = HOLD;
                    end else if (timer == TIMER_LAST) begin
                        drop_nxt  = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        timer_nxt = timer + TIMER_ONE;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        last_pc_nxt = addr_q;
                        seen_nxt    = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        mem_req     = (state == REQ);
        mem_addr    = addr_q;
        instr_valid = (state == HOLD);
        instr       = data_q;
        err         = timeout_hit & ~flush;
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pc_fetch_ctrl;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic             flush;
    logic             same_pc;
    logic             busy;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0] instr;
    logic             instr_valid;
    logic             instr_ready;
    logic             err;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .flush       (flush),
        .same_pc     (same_pc),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .err         (err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int valid_seen = 0;

    // Model: what the fetcher is doing, in transaction terms.
    bit          m_asking;
    bit          m_waiting;
    bit          m_holding;
    bit          m_seen;
    bit          m_drop;
    int          m_age;
    logic [31:0] m_last;
    logic [31:0] m_addr;
    logic [31:0] m_data;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_asking  = 1'b0;
        m_waiting = 1'b0;
        m_holding = 1'b0;
        m_seen    = 1'b0;
        m_drop    = 1'b0;
        m_age     = 0;
        m_last    = '0;
        m_addr    = '0;
        m_data    = '0;
    endtask

    task automatic compare_model();
        bit accepted;
        bit exp_err;
        accepted = mem_rvalid && !m_drop;
        exp_err  = m_waiting && (m_age == TIMEOUT - 1) && !accepted && !flush;
        chk1("same_pc", same_pc, m_seen && (pc == m_last));
        chk1("busy", busy, m_asking || m_waiting || m_holding);
        chk1("mem_req", mem_req, m_asking);
        if (m_asking) chk32("mem_addr", mem_addr, m_addr);
        chk1("instr_valid", instr_valid, m_holding);
        if (m_holding) chk32("instr", instr, m_data);
        chk1("err", err, exp_err);
    endtask

    task automatic model_step();
        bit accepted;
        if (reset) begin
            model_reset();
            return;
        end
        accepted = mem_rvalid && !m_drop;
        if (mem_rvalid && m_drop) m_drop = 1'b0;
        if (flush) begin
            if (m_waiting || (m_asking && mem_gnt)) m_drop = 1'b1;
            m_seen    = 1'b0;
            m_asking  = 1'b0;
            m_waiting = 1'b0;
            m_holding = 1'b0;
        end else if (m_asking) begin
            if (mem_gnt) begin
                m_asking  = 1'b0;
                m_waiting = 1'b1;
                m_age     = 0;
            end
        end else if (m_waiting) begin
            if (accepted) begin
                m_data    = mem_rdata;
                m_waiting = 1'b0;
                m_holding = 1'b1;
            end else if (m_age == TIMEOUT - 1) begin
                m_drop    = 1'b1;
                m_waiting = 1'b0;
                m_asking  = 1'b1;
            end else begin
                m_age++;
            end
        end else if (m_holding) begin
            if (instr_ready) begin
                m_last    = m_addr;
                m_seen    = 1'b1;
                m_holding = 1'b0;
            end
        end else if (pc_valid && !(m_seen && pc == m_last)) begin
            m_addr   = pc;
            m_asking = 1'b1;
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return after the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_model();
        if (err) err_seen++;
        if (instr_valid) valid_seen++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pc = '0; pc_valid = 1'b0; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
        model_reset();
        tick();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk32("rst_instr", instr, 32'h0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // 1: minimum latency fetch
        pc = 32'h100; pc_valid = 1'b1;
        #1; chk1("t1_c0_busy", busy, 1'b0); chk1("t1_c0_same", same_pc, 1'b0);
        tick();
        mem_gnt = 1'b1;
        #1; chk1("t1_c1_req", mem_req, 1'b1); chk32("t1_c1_addr", mem_addr, 32'h100);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rvalid = 1'b0; instr_ready = 1'b1;
        #1; chk1("t1_c3_valid", instr_valid, 1'b1); chk32("t1_c3_instr", instr, 32'hDEADBEEF);
        tick();
        instr_ready = 1'b0;

        // 2: unchanged PC issues nothing
        for (int i = 0; i < 10; i++) begin
            #1;
            chk1("t2_same", same_pc, 1'b1);
            chk1("t2_no_req", mem_req, 1'b0);
            chk1("t2_idle", busy, 1'b0);
            tick();
        end

        // 3: timeout, retry, drop of the late response
        pc = 32'h104;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; err_seen = 0;
        repeat (TIMEOUT) tick();
        chk32("t3_err_pulses", err_seen, 32'd1);
        #1; chk1("t3_retry_req", mem_req, 1'b1); chk32("t3_retry_addr", mem_addr, 32'h104);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111;
        tick();
        mem_rvalid = 1'b0;
        #1; chk1("t3_late_dropped", instr_valid, 1'b0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h2222;
        tick();
        mem_rvalid = 1'b0;

        // 4: backpressure while the PC moves on
        pc = 32'h200;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1("t4_hold_valid", instr_valid, 1'b1);
            chk32("t4_hold_instr", instr, 32'h2222);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1; chk1("t4_back_idle", busy, 1'b0); chk1("t4_not_same", same_pc, 1'b0);
        tick();
        #1; chk1("t4_req", mem_req, 1'b1); chk32("t4_addr", mem_addr, 32'h200);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA0200;
        tick();
        mem_rvalid = 1'b0; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // 5: flush in WAIT, late response must not surface
        pc = 32'h300;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; pc_valid = 1'b0; valid_seen = 0;
        mem_rvalid = 1'b1; mem_rdata = 32'h3333;
        tick();
        mem_rvalid = 1'b0;
        repeat (3) tick();
        chk32("t5_no_valid", valid_seen, 32'd0);
        pc_valid = 1'b1;
        tick();
        #1; chk1("t5_refetch_req", mem_req, 1'b1); chk32("t5_refetch_addr", mem_addr, 32'h300);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3434;
        tick();
        mem_rvalid = 1'b0;
        #1; chk32("t5_instr", instr, 32'h3434);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1; chk1("t5_same_before_flush", same_pc, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1; chk1("t5_forgotten", same_pc, 1'b0);
        tick();
        #1; chk1("t5_idle_flush_refetch", mem_req, 1'b1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555;
        tick();
        mem_rvalid = 1'b0;

        // 6: asynchronous reset while holding a word
        #1; chk1("t6_in_hold", instr_valid, 1'b1);
        reset = 1'b1;
        #1;
        model_reset();
        chk1("t6_rst_valid", instr_valid, 1'b0);
        chk32("t6_rst_instr", instr, 32'h0);
        chk1("t6_rst_busy", busy, 1'b0);
        chk1("t6_rst_same", same_pc, 1'b0);
        tick();
        tick();
        reset = 1'b0; pc = 32'h100; pc_valid = 1'b1;
        tick();
        #1; chk1("t6_fetch_req", mem_req, 1'b1); chk32("t6_fetch_addr", mem_addr, 32'h100);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h600D0100;
        tick();
        mem_rvalid = 1'b0; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            pc_valid = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) pc = 32'h100 + ($urandom_range(0, 3) << 2);
            flush       = ($urandom_range(0, 39) == 0);
            mem_gnt     = ($urandom_range(0, 1) == 1);
            mem_rvalid  = ($urandom_range(0, 9) == 0);
            mem_rdata   = $urandom;
            instr_ready = ($urandom_range(0, 2) == 0);
            reset       = ($urandom_range(0, 499) == 0);
            if (reset) model_reset();
            tick();
        end
        reset = 1'b0; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        instr_ready = 1'b0; pc_valid = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
